// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS decode-control definitions: opcode/funct constants, ALU codes,
// access-size (Trunk) encodings, the ID/EX control word and the halt FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_LWU   = 6'h27;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_NOP   = 6'h3E;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [5:0] ALU_NONE = 6'h00;
    localparam logic [5:0] ALU_ADDU = 6'h21;
    localparam logic [5:0] ALU_AND  = 6'h24;
    localparam logic [5:0] ALU_OR   = 6'h25;
    localparam logic [5:0] ALU_XOR  = 6'h26;
    localparam logic [5:0] ALU_SLT  = 6'h2A;

    localparam logic [1:0] TRUNK_WORD = 2'b00;
    localparam logic [1:0] TRUNK_HALF = 2'b01;
    localparam logic [1:0] TRUNK_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } dc_state_e;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch_eq;
        logic       branch_ne;
        logic       alu_src;
        logic       signed_op;
        logic       shift;
        logic       jump;
        logic       link_r;
        logic [5:0] alu_ctl;
        logic [1:0] trunk;
    } ctrl_t;

endpackage

// File: rtl/dc_decode.sv
// Purely combinational opcode/funct decoder: produces the control word, the
// resolved destination register, whether rt is read as a source, and
// illegal/halt flags.
module dc_decode
    import mips_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    output ctrl_t                 ctrl,
    output logic [REG_ADDR_W-1:0] wreg,
    output logic                  uses_rt,
    output logic                  illegal,
    output logic                  is_halt
);

    // Decode op/funct into control bits; writes to register 0 are dropped at the end.
    always_comb begin
        ctrl    = '0;
        wreg    = '0;
        uses_rt = 1'b0;
        illegal = 1'b0;
        is_halt = 1'b0;
        case (op)
            OP_RTYPE: begin
                uses_rt      = 1'b1;
                ctrl.alu_ctl = funct;
                case (funct)
                    FN_JR: ctrl.jump = 1'b1;
                    FN_JALR: begin
                        ctrl.jump       = 1'b1;
                        ctrl.link_r     = 1'b1;
                        ctrl.shift      = 1'b1;
                        ctrl.mem_to_reg = 1'b1;
                        ctrl.reg_write  = 1'b1;
                        wreg            = rd;
                    end
                    default: begin
                        ctrl.reg_write = 1'b1;
                        wreg           = rd;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                wreg           = rt;
                case (op)
                    OP_ADDI: begin
                        ctrl.alu_ctl   = ALU_ADDU;
                        ctrl.signed_op = 1'b1;
                    end
                    OP_ANDI: ctrl.alu_ctl = ALU_AND;
                    OP_ORI:  ctrl.alu_ctl = ALU_OR;
                    OP_XORI: ctrl.alu_ctl = ALU_XOR;
                    OP_SLTI: ctrl.alu_ctl = ALU_SLT;
                    default: ctrl.shift   = 1'b1;
                endcase
            end
            OP_BEQ: begin
                ctrl.branch_eq = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                uses_rt        = 1'b1;
            end
            OP_J: ctrl.jump = 1'b1;
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.link_r     = 1'b1;
                ctrl.shift      = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                wreg            = '1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctl    = ALU_ADDU;
                ctrl.signed_op  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
                wreg            = rt;
                if ((op == OP_LB) || (op == OP_LBU))
                    ctrl.trunk = TRUNK_BYTE;
                else if ((op == OP_LH) || (op == OP_LHU))
                    ctrl.trunk = TRUNK_HALF;
                else
                    ctrl.trunk = TRUNK_WORD;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctl   = ALU_ADDU;
                ctrl.signed_op = 1'b1;
                uses_rt        = 1'b1;
                if (op == OP_SB)
                    ctrl.trunk = TRUNK_BYTE;
                else if (op == OP_SH)
                    ctrl.trunk = TRUNK_HALF;
                else
                    ctrl.trunk = TRUNK_WORD;
            end
            OP_NOP:  ;
            OP_HALT: is_halt = 1'b1;
            default: illegal = 1'b1;
        endcase
        if (wreg == '0)
            ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// MIPS decode-stage control with registered ID/EX control word, load-use
// bubble insertion, flush squash and HALT drain/halt state machine.
// Optional perf counters are built only when DC_PERF_CNT_EN is defined.
module decode_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int ALUCTL_W     = 6,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_DC_VALID,
    input  logic [5:0]            I_DC_OP,
    input  logic [5:0]            I_DC_FUNCT,
    input  logic [REG_ADDR_W-1:0] I_DC_RS,
    input  logic [REG_ADDR_W-1:0] I_DC_RT,
    input  logic [REG_ADDR_W-1:0] I_DC_RD,
    input  logic                  I_DC_FLUSH,
    output logic                  O_DC_STALL,
    output logic                  O_DC_VALID,
    output logic                  O_DC_MemtoReg,
    output logic                  O_DC_RegWrite,
    output logic                  O_DC_MemWrite,
    output logic                  O_DC_MemRead,
    output logic                  O_DC_BranchEQ,
    output logic                  O_DC_BranchNE,
    output logic                  O_DC_ALUSrc,
    output logic                  O_DC_signed,
    output logic                  O_DC_shift,
    output logic                  O_DC_Jump,
    output logic                  O_DC_LinkR,
    output logic [ALUCTL_W-1:0]   O_DC_ALUControl,
    output logic [1:0]            O_DC_Trunk,
    output logic [REG_ADDR_W-1:0] O_DC_WREG,
    output logic                  O_DC_ILLEGAL,
    output logic                  O_DC_HALTED,
    output logic [CNT_W-1:0]      O_DC_INSTR_CNT,
    output logic [CNT_W-1:0]      O_DC_STALL_CNT
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrl_t                 dec_ctrl;
    logic [REG_ADDR_W-1:0] dec_wreg;
    logic                  dec_uses_rt, dec_illegal, dec_is_halt;

    dc_state_e             state, state_nx;
    logic [DRAIN_W-1:0]    drain_cnt, drain_cnt_nx;
    ctrl_t                 ctrl_p1, ctrl_nx;
    logic [REG_ADDR_W-1:0] wreg_p1, wreg_nx;
    logic                  vld_p1, vld_nx, ill_p1, ill_nx;
    logic                  hazard, stall;

    dc_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
        .op      (I_DC_OP),
        .funct   (I_DC_FUNCT),
        .rt      (I_DC_RT),
        .rd      (I_DC_RD),
        .ctrl    (dec_ctrl),
        .wreg    (dec_wreg),
        .uses_rt (dec_uses_rt),
        .illegal (dec_illegal),
        .is_halt (dec_is_halt)
    );

    // Load-use hazard; HALT reads no registers so it never waits on a load.
    always_comb begin
        hazard = I_DC_VALID && vld_p1 && ctrl_p1.mem_read && (wreg_p1 != '0) &&
                 ((wreg_p1 == I_DC_RS) || ((wreg_p1 == I_DC_RT) && dec_uses_rt)) &&
                 !dec_is_halt;
    end

    // Next-state, next ID/EX word and stall: flush > halt FSM > load-use > normal load.
    always_comb begin
        state_nx     = state;
        drain_cnt_nx = drain_cnt;
        ctrl_nx      = '0;
        wreg_nx      = '0;
        vld_nx       = 1'b0;
        ill_nx       = 1'b0;
        stall        = 1'b0;
        case (state)
            ST_RUN: begin
                if (I_DC_FLUSH) begin
                    // squash: bubble already selected by defaults
                end else if (I_DC_VALID && dec_is_halt) begin
                    vld_nx       = 1'b1;
                    state_nx     = ST_DRAIN;
                    drain_cnt_nx = DRAIN_W'(DRAIN_CYCLES - 1);
                end else if (hazard) begin
                    stall = 1'b1;
                end else if (I_DC_VALID && dec_illegal) begin
                    ill_nx = 1'b1;
                end else if (I_DC_VALID) begin
                    ctrl_nx = dec_ctrl;
                    wreg_nx = dec_wreg;
                    vld_nx  = 1'b1;
                end
            end
            ST_DRAIN: begin
                stall = 1'b1;
                if (drain_cnt == '0)
                    state_nx = ST_HALTED;
                else
                    drain_cnt_nx = drain_cnt - DRAIN_W'(1);
            end
            ST_HALTED: stall = 1'b1;
            default:   state_nx = ST_RUN;
        endcase
    end

    // Halt FSM state and drain counter.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            ctrl_p1 <= '0;
            wreg_p1 <= '0;
            vld_p1  <= 1'b0;
            ill_p1  <= 1'b0;
        end else begin
            ctrl_p1 <= ctrl_nx;
            wreg_p1 <= wreg_nx;
            vld_p1  <= vld_nx;
            ill_p1  <= ill_nx;
        end
    end

    assign O_DC_STALL      = stall;
    assign O_DC_VALID      = vld_p1;
    assign O_DC_MemtoReg   = ctrl_p1.mem_to_reg;
    assign O_DC_RegWrite   = ctrl_p1.reg_write;
    assign O_DC_MemWrite   = ctrl_p1.mem_write;
    assign O_DC_MemRead    = ctrl_p1.mem_read;
    assign O_DC_BranchEQ   = ctrl_p1.branch_eq;
    assign O_DC_BranchNE   = ctrl_p1.branch_ne;
    assign O_DC_ALUSrc     = ctrl_p1.alu_src;
    assign O_DC_signed     = ctrl_p1.signed_op;
    assign O_DC_shift      = ctrl_p1.shift;
    assign O_DC_Jump       = ctrl_p1.jump;
    assign O_DC_LinkR      = ctrl_p1.link_r;
    assign O_DC_ALUControl = ALUCTL_W'(ctrl_p1.alu_ctl);
    assign O_DC_Trunk      = ctrl_p1.trunk;
    assign O_DC_WREG       = wreg_p1;
    assign O_DC_ILLEGAL    = ill_p1;
    assign O_DC_HALTED     = (state == ST_HALTED);

`ifdef DC_PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt, stall_cnt;

    // Perf counters: issued instructions and stalled cycles, wrapping.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (vld_nx)
                instr_cnt <= instr_cnt + CNT_W'(1);
            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign O_DC_INSTR_CNT = instr_cnt;
    assign O_DC_STALL_CNT = stall_cnt;
`else
    assign O_DC_INSTR_CNT = '0;
    assign O_DC_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Table-driven bench for decode_ctrl_pipe plus hand-written reset sequences.
module tb_decode_ctrl_pipe;

    logic        clk, rst;
    logic        valid, flush;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic        stall, vld;
    logic        m2r, rw, mw, mr, beq, bne, asrc, sgn, shf, jmp, lnk;
    logic [5:0]  aluc;
    logic [1:0]  trunk;
    logic [4:0]  wreg;
    logic        ill, halted;
    logic [31:0] icnt, scnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_icnt = 0;
    int exp_scnt = 0;

    typedef struct {
        logic        v;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic        fl;
        logic        e_st, e_vld;
        logic [10:0] e_ctl;
        logic [5:0]  e_alu;
        logic [1:0]  e_tr;
        logic [4:0]  e_wr;
        logic        e_ill, e_hlt;
    } vec_t;

    vec_t tv[32];

    decode_ctrl_pipe dut (
        .I_CLK(clk), .I_RST(rst), .I_DC_VALID(valid), .I_DC_OP(op), .I_DC_FUNCT(fn),
        .I_DC_RS(rs), .I_DC_RT(rt), .I_DC_RD(rd), .I_DC_FLUSH(flush),
        .O_DC_STALL(stall), .O_DC_VALID(vld),
        .O_DC_MemtoReg(m2r), .O_DC_RegWrite(rw), .O_DC_MemWrite(mw), .O_DC_MemRead(mr),
        .O_DC_BranchEQ(beq), .O_DC_BranchNE(bne), .O_DC_ALUSrc(asrc), .O_DC_signed(sgn),
        .O_DC_shift(shf), .O_DC_Jump(jmp), .O_DC_LinkR(lnk),
        .O_DC_ALUControl(aluc), .O_DC_Trunk(trunk), .O_DC_WREG(wreg),
        .O_DC_ILLEGAL(ill), .O_DC_HALTED(halted),
        .O_DC_INSTR_CNT(icnt), .O_DC_STALL_CNT(scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic v, logic [5:0] o, logic [5:0] f, logic [4:0] s, logic [4:0] t,
                                logic [4:0] d, logic fl, logic st, logic vl, logic [10:0] ctl,
                                logic [5:0] alu, logic [1:0] tr, logic [4:0] wr, logic il, logic hl);
        vec_t r;
        r.v = v; r.op = o; r.fn = f; r.rs = s; r.rt = t; r.rd = d; r.fl = fl;
        r.e_st = st; r.e_vld = vl; r.e_ctl = ctl; r.e_alu = alu; r.e_tr = tr;
        r.e_wr = wr; r.e_ill = il; r.e_hlt = hl;
        return r;
    endfunction

    function automatic logic [26:0] outs();
        return {vld, m2r, rw, mw, mr, beq, bne, asrc, sgn, shf, jmp, lnk, aluc, trunk, wreg, ill, halted};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic check_counters(input string nm);
`ifdef DC_PERF_CNT_EN
        chk({nm, "_instr_cnt"}, icnt, exp_icnt);
        chk({nm, "_stall_cnt"}, scnt, exp_scnt);
`else
        chk({nm, "_instr_cnt"}, icnt, 32'd0);
        chk({nm, "_stall_cnt"}, scnt, 32'd0);
`endif
    endtask

    // Called at posedge+1: drive ID, check comb stall, clock, check ID/EX outputs.
    task automatic apply(input vec_t t, input string nm);
        logic [26:0] e;
        valid = t.v; op = t.op; fn = t.fn; rs = t.rs; rt = t.rt; rd = t.rd; flush = t.fl;
        #1;
        chk({nm, "_stall"}, 32'(stall), 32'(t.e_st));
        @(posedge clk);
        #1;
        e = {t.e_vld, t.e_ctl, t.e_alu, t.e_tr, t.e_wr, t.e_ill, t.e_hlt};
        chk({nm, "_out"}, 32'(outs()), 32'(e));
        exp_icnt += int'(t.e_vld);
        exp_scnt += int'(t.e_st);
    endtask

    initial begin
        //            v  op    fn    rs rt rd fl  st vl ctl    alu   tr wr il hl
        tv[0]  = mk(1, 'h08, 0,    1, 2, 0, 0,  0, 1, 'h218, 'h21, 0, 2, 0, 0); // ADDI
        tv[1]  = mk(1, 'h00, 'h20, 1, 2, 3, 0,  0, 1, 'h200, 'h20, 0, 3, 0, 0); // ADD
        tv[2]  = mk(1, 'h23, 0,    1, 5, 0, 0,  0, 1, 'h698, 'h21, 0, 5, 0, 0); // LW $5
        tv[3]  = mk(1, 'h00, 'h20, 5, 2, 6, 0,  1, 0, 0,     0,    0, 0, 0, 0); // ADD rs=$5 stalls
        tv[4]  = mk(1, 'h00, 'h20, 5, 2, 6, 0,  0, 1, 'h200, 'h20, 0, 6, 0, 0); // ADD issues
        tv[5]  = mk(1, 'h23, 0,    1, 5, 0, 0,  0, 1, 'h698, 'h21, 0, 5, 0, 0); // LW $5
        tv[6]  = mk(1, 'h2B, 0,    1, 5, 0, 0,  1, 0, 0,     0,    0, 0, 0, 0); // SW rt=$5 stalls
        tv[7]  = mk(1, 'h2B, 0,    1, 5, 0, 0,  0, 1, 'h118, 'h21, 0, 0, 0, 0); // SW issues
        tv[8]  = mk(1, 'h23, 0,    1, 5, 0, 0,  0, 1, 'h698, 'h21, 0, 5, 0, 0); // LW $5
        tv[9]  = mk(1, 'h08, 0,    1, 5, 0, 0,  0, 1, 'h218, 'h21, 0, 5, 0, 0); // ADDI rt=$5: no stall
        tv[10] = mk(1, 'h23, 0,    1, 0, 0, 0,  0, 1, 'h498, 'h21, 0, 0, 0, 0); // LW $0: no RegWrite
        tv[11] = mk(1, 'h00, 'h20, 0, 0, 7, 0,  0, 1, 'h200, 'h20, 0, 7, 0, 0); // ADD rs=$0: no stall
        tv[12] = mk(1, 'h20, 0,    1, 4, 0, 0,  0, 1, 'h698, 'h21, 2, 4, 0, 0); // LB
        tv[13] = mk(1, 'h25, 0,    2, 8, 0, 0,  0, 1, 'h690, 'h21, 1, 8, 0, 0); // LHU
        tv[14] = mk(1, 'h03, 0,    0, 0, 0, 0,  0, 1, 'h607, 0,    0, 31, 0, 0); // JAL
        tv[15] = mk(1, 'h3D, 0,    0, 0, 0, 0,  0, 0, 0,     0,    0, 0, 1, 0); // illegal
        tv[16] = mk(1, 'h3E, 0,    0, 0, 0, 0,  0, 1, 0,     0,    0, 0, 0, 0); // NOP
        tv[17] = mk(1, 'h04, 0,    1, 2, 0, 0,  0, 1, 'h040, 0,    0, 0, 0, 0); // BEQ
        tv[18] = mk(0, 'h08, 0,    1, 2, 0, 0,  0, 0, 0,     0,    0, 0, 0, 0); // not valid
        tv[19] = mk(1, 'h08, 0,    1, 2, 0, 1,  0, 0, 0,     0,    0, 0, 0, 0); // flushed ADDI
        tv[20] = mk(1, 'h00, 'h09, 1, 0, 9, 0,  0, 1, 'h607, 'h09, 0, 9, 0, 0); // JALR
        tv[21] = mk(1, 'h00, 'h08, 31, 0, 0, 0, 0, 1, 'h002, 'h08, 0, 0, 0, 0); // JR
        tv[22] = mk(1, 'h0F, 0,    0, 3, 0, 0,  0, 1, 'h214, 0,    0, 3, 0, 0); // LUI
        tv[23] = mk(1, 'h3F, 0,    0, 0, 0, 1,  0, 0, 0,     0,    0, 0, 0, 0); // HALT flushed
        tv[24] = mk(1, 'h3D, 0,    0, 0, 0, 1,  0, 0, 0,     0,    0, 0, 0, 0); // illegal flushed
        tv[25] = mk(1, 'h23, 0,    1, 5, 0, 0,  0, 1, 'h698, 'h21, 0, 5, 0, 0); // LW $5
        tv[26] = mk(1, 'h00, 'h20, 5, 2, 6, 1,  0, 0, 0,     0,    0, 0, 0, 0); // flush cancels stall
        tv[27] = mk(1, 'h3F, 0,    0, 0, 0, 0,  0, 1, 0,     0,    0, 0, 0, 0); // HALT
        tv[28] = mk(1, 'h08, 0,    1, 2, 0, 0,  1, 0, 0,     0,    0, 0, 0, 0); // drain
        tv[29] = mk(1, 'h08, 0,    1, 2, 0, 0,  1, 0, 0,     0,    0, 0, 0, 0); // drain
        tv[30] = mk(1, 'h08, 0,    1, 2, 0, 0,  1, 0, 0,     0,    0, 0, 0, 1); // halted
        tv[31] = mk(1, 'h08, 0,    1, 2, 0, 1,  1, 0, 0,     0,    0, 0, 0, 1); // halted, flush ignored

        valid = 0; flush = 0; op = 0; fn = 0; rs = 0; rt = 0; rd = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 32'(outs()), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        check_counters("reset");
        rst = 1'b0;

        for (int i = 0; i < 32; i++)
            apply(tv[i], $sformatf("vec%0d", i));
        check_counters("table");

        // Reset out of HALTED clears the sticky flag and the stall at once.
        #2;
        rst = 1'b1;
        exp_icnt = 0; exp_scnt = 0;
        #1;
        chk("rst_halted_flag", 32'(halted), 32'd0);
        chk("rst_halted_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset in the middle of DRAIN, then normal decode resumes.
        apply(mk(1, 'h3F, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "drain_halt");
        apply(mk(1, 'h08, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "drain_step");
        rst = 1'b1;
        exp_icnt = 0; exp_scnt = 0;
        #1;
        chk("rst_drain_stall", 32'(stall), 32'd0);
        chk("rst_drain_out", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk(1, 'h08, 0, 1, 2, 0, 0, 0, 1, 'h218, 'h21, 0, 2, 0, 0), "post_rst_addi");
        apply(mk(1, 'h08, 0, 1, 2, 0, 0, 0, 1, 'h218, 'h21, 0, 2, 0, 0), "post_rst_addi2");
        check_counters("final");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
